// File: rtl/top.sv
// Board top: 4-bit adder/subtractor shown on a 4-digit common-anode display.
// Right to left the digits show A, B, (A+B) mod 16 and (A-B) mod 16.
module top #(
   parameter int DIVIDE_BY = 100000
) (
   input  logic       clk,
   input  logic       btnC,
   input  logic [7:0] sw,
   output logic [3:0] an,
   output logic [6:0] seg
);

   localparam int unsigned TERM  = 2 * DIVIDE_BY - 1;
   localparam int          CNT_W = (TERM < 2) ? 1 : $clog2(TERM + 1);
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TERM);

   logic [CNT_W-1:0] refreshCount;
   logic [1:0]       digitIdx;
   logic [3:0]       opA;
   logic [3:0]       opB;
   logic [3:0]       sumVal;
   logic [3:0]       diffVal;
   logic [3:0]       digitVal;

   // The digit steps on the same edge that the refresh counter wraps.
   always_ff @(posedge clk or negedge btnC) begin
      if (!btnC) begin
         refreshCount <= '0;
         digitIdx     <= 2'd0;
      end else if (refreshCount == TERM_CNT) begin
         refreshCount <= '0;
         digitIdx     <= digitIdx + 2'd1;
      end else begin
         refreshCount <= refreshCount + CNT_W'(1);
      end
   end

   assign opA     = sw[3:0];
   assign opB     = sw[7:4];
   assign sumVal  = opA + opB;
   assign diffVal = opA - opB;

   always_comb begin
      digitVal = opA;
      case (digitIdx)
         2'd0: digitVal = opA;
         2'd1: digitVal = opB;
         2'd2: digitVal = sumVal;
         2'd3: digitVal = diffVal;
         default: digitVal = opA;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : gAnode
         assign an[gi] = ~(digitIdx == 2'(gi));
      end
   endgenerate

   // Active-low {G,F,E,D,C,B,A}; anything unrecognised shows "U".
   function automatic logic [6:0] hexToSeg(input logic [3:0] v);
      case (v)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         4'hF: return 7'b0001110;
         default: return 7'b1000001;
      endcase
   endfunction

   assign seg = hexToSeg(digitVal);

endmodule

// File: tb/tb_top.sv
// Bench for top with DIVIDE_BY=1: scan order, arithmetic, combinational
// update and asynchronous reset against an edge-counting reference model.
module tb_top;

   logic       clk = 1'b0;
   logic       btnC = 1'b1;
   logic [7:0] sw = 8'h00;
   logic [3:0] an;
   logic [6:0] seg;

   int checks = 0;
   int errors = 0;
   int edges  = 0;

   logic [6:0] encTab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   top #(.DIVIDE_BY(1)) dut (
      .clk (clk),
      .btnC(btnC),
      .sw  (sw),
      .an  (an),
      .seg (seg)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      if (btnC) edges++;
      #1;
   endtask

   function automatic int expDigit();
      return (edges / 2) % 4;
   endfunction

   task automatic checkOutputs(input string tag);
      int         d;
      int         a;
      int         b;
      int         v;
      logic [3:0] one;
      logic [3:0] expAn;
      logic [6:0] expSeg;
      d   = expDigit();
      a   = int'(sw[3:0]);
      b   = int'(sw[7:4]);
      one = 4'b0001;
      expAn = ~(one << d);
      case (d)
         0: v = a;
         1: v = b;
         2: v = (a + b) % 16;
         default: v = (a - b + 16) % 16;
      endcase
      expSeg = encTab[v];
      checks++;
      assert (an === expAn)
      else begin
         errors++;
         $error("FAIL %s an: sw=%h got %b expected %b", tag, sw, an, expAn);
      end
      checks++;
      assert (seg === expSeg)
      else begin
         errors++;
         $error("FAIL %s seg: sw=%h digit=%0d got %b expected %b", tag, sw, d, seg, expSeg);
      end
   endtask

   task automatic runDigits(input logic [7:0] val, input string tag);
      sw = val;
      #1;
      checkOutputs(tag);
      for (int i = 0; i < 8; i++) begin
         tick();
         checkOutputs(tag);
      end
      $display("%s: sw=%h scanned 8 edges, errors so far %0d", tag, val, errors);
   endtask

   task automatic seekDigit(input int target);
      int budget;
      budget = 0;
      while (expDigit() != target && budget < 20) begin
         tick();
         budget++;
      end
      checks++;
      assert (expDigit() == target)
      else begin
         errors++;
         $error("FAIL seek: digit %0d expected %0d", expDigit(), target);
      end
   endtask

   initial begin
      // Reset with switches at zero, no clock edge needed.
      #2 btnC = 1'b0;
      edges = 0;
      #1;
      checkOutputs("reset");
      $display("reset: an=%b seg=%b", an, seg);
      tick();
      checkOutputs("reset_held");
      #2 btnC = 1'b1;
      edges = 0;

      runDigits(8'h00, "scan");
      runDigits(8'h23, "basic");
      runDigits(8'hF9, "wrap");
      runDigits(8'h10, "borrow");

      // Combinational update while parked on the sum digit.
      seekDigit(2);
      sw = 8'h11;
      #1;
      checkOutputs("comb_before");
      sw = 8'h57;
      #1;
      checkOutputs("comb_after");
      checks++;
      assert (seg === 7'b1000110)
      else begin
         errors++;
         $error("FAIL comb_encC: got %b expected %b", seg, 7'b1000110);
      end
      $display("comb: sw=57 seg=%b", seg);

      for (int v = 0; v < 256; v++) begin
         sw = 8'(v);
         #1;
         checkOutputs("exhaustive");
         for (int i = 0; i < 8; i++) begin
            tick();
            checkOutputs("exhaustive");
         end
      end
      $display("exhaustive: 256 operand pairs scanned, errors so far %0d", errors);

      for (int i = 0; i < 300; i++) begin
         sw = 8'($urandom);
         #1;
         checkOutputs("random_comb");
         tick();
         checkOutputs("random");
      end
      $display("random: 300 steps, errors so far %0d", errors);

      // Reset asserted mid-scan at the sum digit.
      seekDigit(2);
      sw = 8'($urandom);
      #1;
      btnC = 1'b0;
      edges = 0;
      #1;
      checkOutputs("midreset");
      checks++;
      assert (an === 4'b1110)
      else begin
         errors++;
         $error("FAIL midreset_an: got %b expected %b", an, 4'b1110);
      end
      $display("midreset: an=%b", an);
      tick();
      checkOutputs("midreset_held");
      #2 btnC = 1'b1;
      edges = 0;
      runDigits(8'h4C, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
